cdb_arbiter: RTL and testbench

//  Shares the two CDBs (cdb1/cdb2) among NUM_FU functional units (adders, mult, memory).
//  One result-holding slot per FU; each cycle up to two slots win CDB broadcast by round-robin.
//  CDB outputs feed rs/ROB/PRF rs_cdb*_in/tag/valid; fu_ready feeds the rs *_available inputs.

---
 rtl/cdb_arbiter_pkg.sv | 22 ++
 rtl/cdb_arbiter_if.sv | 28 ++
 rtl/cdb_arbiter_rr_pick2.sv | 29 ++
 rtl/cdb_arbiter.sv | 65 ++++++
 tb/tb_cdb_arbiter.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared widths, FU indices and the CDB packet type for the CDB arbiter
package cdb_arbiter_pkg;
  localparam int NUM_FU = 4;
  localparam int PRN_SIZE = 64;
  localparam int ROB_SIZE = 32;
  localparam int TW = $clog2(PRN_SIZE);
  localparam int RW = $clog2(ROB_SIZE);
  localparam int PW = $clog2(NUM_FU);
  localparam int FU_ADD0 = 0;
  localparam int FU_ADD1 = 1;
  localparam int FU_MULT = 2;
  localparam int FU_MEM = 3;
  typedef struct packed {
    logic valid;
    logic [63:0] value;
    logic [TW-1:0] tag;
    logic [RW-1:0] rob_idx;
  } cdb_packet_t;
  function automatic logic [PW-1:0] ring_idx(input logic [PW-1:0] base, input int off);
    return PW'((int'(base) + off) % NUM_FU);
  endfunction
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: FU result handshake plus the two CDB broadcast buses
interface cdb_arbiter_if;
  import cdb_arbiter_pkg::*;
  logic flush;
  logic [NUM_FU-1:0] fu_valid;
  logic [NUM_FU-1:0][63:0] fu_result;
  logic [NUM_FU-1:0][TW-1:0] fu_dest_tag;
  logic [NUM_FU-1:0][RW-1:0] fu_rob_idx;
  logic [NUM_FU-1:0] fu_ready;
  logic cdb1_valid;
  logic [63:0] cdb1_value;
  logic [TW-1:0] cdb1_tag;
  logic [RW-1:0] cdb1_rob_idx;
  logic cdb2_valid;
  logic [63:0] cdb2_value;
  logic [TW-1:0] cdb2_tag;
  logic [RW-1:0] cdb2_rob_idx;
  modport master (
    output flush, fu_valid, fu_result, fu_dest_tag, fu_rob_idx,
    input fu_ready, cdb1_valid, cdb1_value, cdb1_tag, cdb1_rob_idx,
    input cdb2_valid, cdb2_value, cdb2_tag, cdb2_rob_idx
  );
  modport slave (
    input flush, fu_valid, fu_result, fu_dest_tag, fu_rob_idx,
    output fu_ready, cdb1_valid, cdb1_value, cdb1_tag, cdb1_rob_idx,
    output cdb2_valid, cdb2_value, cdb2_tag, cdb2_rob_idx
  );
endinterface

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2: picks the first two requesters at or after ptr, in cyclic order
module rr_pick2
  import cdb_arbiter_pkg::*;
(
  input  logic [NUM_FU-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic              gnt1_valid,
  output logic [PW-1:0]     gnt1_idx,
  output logic              gnt2_valid,
  output logic [PW-1:0]     gnt2_idx
);
  always_comb begin
    gnt1_valid = 1'b0;
    gnt1_idx = '0;
    gnt2_valid = 1'b0;
    gnt2_idx = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (req[ring_idx(ptr, k)]) begin
        if (!gnt1_valid) begin
          gnt1_valid = 1'b1;
          gnt1_idx = ring_idx(ptr, k);
        end else if (!gnt2_valid) begin
          gnt2_valid = 1'b1;
          gnt2_idx = ring_idx(ptr, k);
        end
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-FU result slots drained onto two CDBs by a two-grant round robin
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input logic clock,
  input logic reset,
  cdb_arbiter_if.slave bus
);
  cdb_packet_t slot [NUM_FU];
  cdb_packet_t cdb1_q, cdb2_q;
  logic [PW-1:0] rr_ptr;
  logic [NUM_FU-1:0] slot_full, grant;
  logic g1v, g2v;
  logic [PW-1:0] g1i, g2i;
  rr_pick2 u_pick (
    .req(slot_full),
    .ptr(rr_ptr),
    .gnt1_valid(g1v),
    .gnt1_idx(g1i),
    .gnt2_valid(g2v),
    .gnt2_idx(g2i)
  );
  always_comb begin
    slot_full = '0;
    grant = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      slot_full[i] = slot[i].valid;
      grant[i] = (g1v && g1i == PW'(i)) || (g2v && g2i == PW'(i));
    end
  end
  // A slot being broadcast this cycle can take a new result on the same edge
  assign bus.fu_ready = ~slot_full | grant;
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) slot[i] <= '0;
      cdb1_q <= '0;
      cdb2_q <= '0;
      rr_ptr <= '0;
    end else if (bus.flush) begin
      for (int i = 0; i < NUM_FU; i++) slot[i] <= '0;
      cdb1_q.valid <= 1'b0;
      cdb2_q.valid <= 1'b0;
      rr_ptr <= '0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (grant[i]) slot[i].valid <= 1'b0;
        if (bus.fu_valid[i] && bus.fu_ready[i])
          slot[i] <= '{valid: 1'b1, value: bus.fu_result[i], tag: bus.fu_dest_tag[i], rob_idx: bus.fu_rob_idx[i]};
      end
      cdb1_q.valid <= g1v;
      cdb2_q.valid <= g2v;
      if (g1v) cdb1_q <= slot[g1i];
      if (g2v) cdb2_q <= slot[g2i];
      rr_ptr <= g2v ? ring_idx(g2i, 1) : g1v ? ring_idx(g1i, 1) : rr_ptr;
    end
  end
  assign bus.cdb1_valid = cdb1_q.valid;
  assign bus.cdb1_value = cdb1_q.value;
  assign bus.cdb1_tag = cdb1_q.tag;
  assign bus.cdb1_rob_idx = cdb1_q.rob_idx;
  assign bus.cdb2_valid = cdb2_q.valid;
  assign bus.cdb2_value = cdb2_q.value;
  assign bus.cdb2_tag = cdb2_q.tag;
  assign bus.cdb2_rob_idx = cdb2_q.rob_idx;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios with a broadcast-order scoreboard for cdb_arbiter
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;
  logic clk, rst;
  int checks = 0;
  int failures = 0;
  cdb_packet_t q[$];
  cdb_arbiter_if bus ();
  cdb_arbiter dut (.clock(clk), .reset(rst), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask
  task automatic load(input int i, input logic [63:0] v, input logic [TW-1:0] t, input logic [RW-1:0] r);
    bus.fu_valid[i] = 1'b1;
    bus.fu_result[i] = v;
    bus.fu_dest_tag[i] = t;
    bus.fu_rob_idx[i] = r;
  endtask
  task automatic push(input logic [63:0] v, input logic [TW-1:0] t, input logic [RW-1:0] r);
    q.push_back('{valid: 1'b1, value: v, tag: t, rob_idx: r});
  endtask
  task automatic sb_pop(input string name, input logic [63:0] v, input logic [TW-1:0] t, input logic [RW-1:0] r);
    cdb_packet_t e;
    checks++;
    assert (q.size() > 0) else begin
      failures++;
      $error("FAIL %s unexpected broadcast observed=%0h expected=none", name, v);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check(name, {v, t, r}, {e.value, e.tag, e.rob_idx});
    end
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.cdb1_valid) sb_pop("sb_cdb1", bus.cdb1_value, bus.cdb1_tag, bus.cdb1_rob_idx);
      if (bus.cdb2_valid) sb_pop("sb_cdb2", bus.cdb2_value, bus.cdb2_tag, bus.cdb2_rob_idx);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    rst = 1'b1;
    bus.flush = 1'b0;
    bus.fu_valid = '0;
    bus.fu_result = '0;
    bus.fu_dest_tag = '0;
    bus.fu_rob_idx = '0;
    tick();
    tick();
    check("rst_cdb1_valid", bus.cdb1_valid, 0);
    check("rst_cdb1_value", bus.cdb1_value, 0);
    check("rst_cdb1_tag", bus.cdb1_tag, 0);
    check("rst_cdb1_rob", bus.cdb1_rob_idx, 0);
    check("rst_cdb2_valid", bus.cdb2_valid, 0);
    check("rst_cdb2_value", bus.cdb2_value, 0);
    check("rst_ready", bus.fu_ready, 4'b1111);
    rst = 1'b0;
    load(FU_MULT, 64'h4000_0000_0000_0000, 'h20, 'h10);
    push(64'h4000_0000_0000_0000, 'h20, 'h10);
    tick();
    bus.fu_valid = '0;
    check("single_c1_valid", bus.cdb1_valid, 0);
    check("single_c1_ready", bus.fu_ready, 4'b1111);
    tick();
    check("single_c2_valid1", bus.cdb1_valid, 1);
    check("single_c2_value", bus.cdb1_value, 64'h4000_0000_0000_0000);
    check("single_c2_tag", bus.cdb1_tag, 'h20);
    check("single_c2_rob", bus.cdb1_rob_idx, 'h10);
    check("single_c2_valid2", bus.cdb2_valid, 0);
    tick();
    check("single_c3_valid1", bus.cdb1_valid, 0);
    check("single_c3_hold", bus.cdb1_value, 64'h4000_0000_0000_0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      load(i, 64'h3000 + 64'(i), TW'(8 + i), RW'(4 + i));
      push(64'h3000 + 64'(i), TW'(8 + i), RW'(4 + i));
    end
    tick();
    bus.fu_valid = '0;
    check("all_c1_ready", bus.fu_ready, 4'b0011);
    tick();
    check("all_c2_valid", {bus.cdb1_valid, bus.cdb2_valid}, 2'b11);
    check("all_c2_cdb1", bus.cdb1_value, 64'h3000);
    check("all_c2_cdb2", bus.cdb2_value, 64'h3001);
    tick();
    check("all_c3_cdb1", bus.cdb1_value, 64'h3002);
    check("all_c3_cdb2", bus.cdb2_value, 64'h3003);
    tick();
    check("all_c4_valid", {bus.cdb1_valid, bus.cdb2_valid}, 2'b00);
    load(FU_MULT, 64'h5002, 'h12, 'h2);
    push(64'h5002, 'h12, 'h2);
    tick();
    bus.fu_valid = '0;
    tick();
    load(FU_MEM, 64'h5003, 'h13, 'h3);
    load(FU_ADD0, 64'h5000, 'h10, 'h0);
    push(64'h5003, 'h13, 'h3);
    push(64'h5000, 'h10, 'h0);
    tick();
    bus.fu_valid = '0;
    tick();
    check("wrap_valid", {bus.cdb1_valid, bus.cdb2_valid}, 2'b11);
    check("wrap_cdb1", bus.cdb1_value, 64'h5003);
    check("wrap_cdb2", bus.cdb2_value, 64'h5000);
    load(FU_ADD0, 64'h5100, 'h20, 'h0);
    load(FU_ADD1, 64'h5101, 'h21, 'h1);
    push(64'h5101, 'h21, 'h1);
    push(64'h5100, 'h20, 'h0);
    tick();
    bus.fu_valid = '0;
    tick();
    check("ptr1_cdb1", bus.cdb1_value, 64'h5101);
    check("ptr1_cdb2", bus.cdb2_value, 64'h5100);
    for (int i = 0; i < NUM_FU; i++) load(i, 64'h4400 + 64'(i), TW'(i), RW'(i));
    push(64'h4401, 'h1, 'h1);
    push(64'h4402, 'h2, 'h2);
    push(64'h4403, 'h3, 'h3);
    push(64'h4400, 'h0, 'h0);
    tick();
    bus.fu_valid = 4'b1000;
    load(FU_MEM, 64'h1, 'h3f, 'h1f);
    push(64'h1, 'h3f, 'h1f);
    check("bp_c1_ready", bus.fu_ready, 4'b0110);
    tick();
    check("bp_c2_cdb1", bus.cdb1_value, 64'h4401);
    check("bp_c2_cdb2", bus.cdb2_value, 64'h4402);
    check("bp_c2_ready", bus.fu_ready, 4'b1111);
    tick();
    bus.fu_valid = '0;
    check("bp_c3_cdb1", bus.cdb1_value, 64'h4403);
    check("bp_c3_cdb2", bus.cdb2_value, 64'h4400);
    tick();
    check("bp_c4_valid", {bus.cdb1_valid, bus.cdb2_valid}, 2'b10);
    check("bp_c4_cdb1", bus.cdb1_value, 64'h1);
    tick();
    check("bp_c5_valid", {bus.cdb1_valid, bus.cdb2_valid}, 2'b00);
    for (int i = 0; i < NUM_FU; i++) load(i, 64'h6600 + 64'(i), TW'(i), RW'(i));
    tick();
    bus.fu_valid = '0;
    bus.flush = 1'b1;
    load(FU_ADD1, 64'h6611, 'h11, 'h11);
    check("flush_pre_ready", bus.fu_ready, 4'b0011);
    check("flush_pre_valid", {bus.cdb1_valid, bus.cdb2_valid}, 2'b00);
    tick();
    bus.flush = 1'b0;
    bus.fu_valid = '0;
    check("flush_valid", {bus.cdb1_valid, bus.cdb2_valid}, 2'b00);
    check("flush_ready", bus.fu_ready, 4'b1111);
    repeat (4) tick();
    check("flush_quiet", {bus.cdb1_valid, bus.cdb2_valid}, 2'b00);
    check("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
